// File: rtl/program_loader_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_ctrl_pkg
// Brief   : Shared loader constants and state encoding (also used by debug).
// Revision: 1.0 - initial release
// ============================================================================
package program_loader_ctrl_pkg;

    localparam int               c_NB_BYTE        = 8;
    localparam int               c_NB_INSTRUCTION = 16;
    localparam logic [15:0]      c_HALT_WORD      = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4,
        ST_OVERFLOW  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_ctrl_byte_to_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_ctrl_byte_to_word_assembler
// Brief   : Holds the low byte and builds the little-endian instruction word.
// Revision: 1.0 - initial release
// ============================================================================
module program_loader_ctrl_byte_to_word_assembler #(
    parameter int NB_BYTE = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load_low,
    input  logic                 i_load_high,
    input  logic [NB_BYTE-1:0]   i_byte,
    output logic [2*NB_BYTE-1:0] o_word
);

    logic [NB_BYTE-1:0] r_low_byte;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_low_byte <= '0;
            o_word     <= '0;
        end else begin
            if (i_load_low)
                r_low_byte <= i_byte;
            if (i_load_high)
                o_word <= {i_byte, r_low_byte};
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_ctrl
// Brief   : Loads a UART byte stream into instruction RAM until HALT or full.
// Revision: 1.0 - initial release
// ============================================================================
module program_loader_ctrl
    import program_loader_ctrl_pkg::*;
#(
    parameter int                        NB_INSTRUCTION = c_NB_INSTRUCTION,
    parameter int                        NB_ADDR        = 10,
    parameter int                        NB_BYTE        = c_NB_BYTE,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = c_HALT_WORD
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_BYTE-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_ram_write_enable,
    output logic [NB_ADDR-1:0]        o_ram_write_address,
    output logic [NB_INSTRUCTION-1:0] o_ram_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic [NB_ADDR:0]          o_word_count,
    output logic                      o_cpu_enable
);

    localparam int RAM_DEPTH = 2**NB_ADDR;

    state_t                    r_state;
    logic [NB_ADDR-1:0]        r_address;
    logic [NB_ADDR:0]          r_count;
    logic                      r_write_enable;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_overflow;
    logic [NB_INSTRUCTION-1:0] w_word;
    logic                      w_halt;
    logic                      w_last_address;
    logic                      w_load_low;
    logic                      w_load_high;

    assign w_halt         = (w_word == HALT_WORD);
    assign w_last_address = (r_address == NB_ADDR'(RAM_DEPTH - 1));

    // A byte arriving in the WRITE cycle is the next low byte unless the load ends there.
    assign w_load_low  = i_rx_valid &&
                         ((r_state == ST_WAIT_LOW) ||
                          ((r_state == ST_WRITE) && !w_halt && !w_last_address));
    assign w_load_high = i_rx_valid && (r_state == ST_WAIT_HIGH);

    program_loader_ctrl_byte_to_word_assembler #(
        .NB_BYTE     (NB_BYTE)
    ) u_byte_to_word_assembler (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load_low  (w_load_low),
        .i_load_high (w_load_high),
        .i_byte      (i_rx_data),
        .o_word      (w_word)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_address      <= '0;
            r_count        <= '0;
            r_write_enable <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_OVERFLOW: begin
                    if (i_start) begin
                        r_state    <= ST_WAIT_LOW;
                        r_address  <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (i_rx_valid)
                        r_state <= ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (i_rx_valid) begin
                        r_state        <= ST_WRITE;
                        r_write_enable <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_count <= r_count + 1'b1;
                    if (w_halt) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_last_address) begin
                        r_state    <= ST_OVERFLOW;
                        r_overflow <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_address <= r_address + 1'b1;
                        r_state   <= i_rx_valid ? ST_WAIT_HIGH : ST_WAIT_LOW;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ram_write_enable  = r_write_enable;
    assign o_ram_write_address = r_address;
    assign o_ram_data          = w_word;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_overflow          = r_overflow;
    assign o_word_count        = r_count;
    assign o_cpu_enable        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_program_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader_ctrl
// Brief   : Self-checking bench for program_loader_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_program_loader_ctrl;

    localparam int NB_ADDR = 5;
    localparam int DEPTH   = 1 << NB_ADDR;

    logic               i_clock    = 1'b0;
    logic               i_reset    = 1'b1;
    logic               i_start    = 1'b0;
    logic               i_rx_valid = 1'b0;
    logic [7:0]         i_rx_data  = 8'h00;
    logic               o_ram_write_enable;
    logic [NB_ADDR-1:0] o_ram_write_address;
    logic [15:0]        o_ram_data;
    logic               o_busy;
    logic               o_done;
    logic               o_overflow;
    logic [NB_ADDR:0]   o_word_count;
    logic               o_cpu_enable;

    program_loader_ctrl #(.NB_ADDR(NB_ADDR)) dut (
        .i_clock             (i_clock),
        .i_reset             (i_reset),
        .i_start             (i_start),
        .i_rx_data           (i_rx_data),
        .i_rx_valid          (i_rx_valid),
        .o_ram_write_enable  (o_ram_write_enable),
        .o_ram_write_address (o_ram_write_address),
        .o_ram_data          (o_ram_data),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_overflow          (o_overflow),
        .o_word_count        (o_word_count),
        .o_cpu_enable        (o_cpu_enable)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               start;
        logic               valid;
        logic [7:0]         data;
        logic               we;
        logic [NB_ADDR-1:0] addr;
        logic [15:0]        wdata;
        logic               busy;
        logic               done;
        logic               ovf;
        int                 count;
    } vec_t;

    typedef struct {
        logic [NB_ADDR-1:0] a;
        logic [15:0]        d;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic we, input int a, input logic [15:0] wd,
                                input logic b, input logic dn, input logic ov, input int c);
        vec_t t;
        t.start = s; t.valid = v; t.data = d; t.we = we; t.addr = NB_ADDR'(a);
        t.wdata = wd; t.busy = b; t.done = dn; t.ovf = ov; t.count = c;
        return t;
    endfunction

    // Every write strobe must match the next write the reference model predicted.
    wr_t mon_e;
    always @(negedge i_clock) begin
        if (mon_en && o_ram_write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         o_ram_write_address, o_ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(o_ram_write_address), 32'(mon_e.a));
                check("write_data", 32'(o_ram_data), 32'(mon_e.d));
            end
        end
    end

    task automatic tick(input logic s, input logic v, input logic [7:0] d);
        i_start = s; i_rx_valid = v; i_rx_data = d;
        @(posedge i_clock);
        #1;
        i_start = 1'b0; i_rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        tick(1'b0, 1'b1, b);
        repeat (gap) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(o_ram_write_enable),  0);
        check({tag, "_addr"},  32'(o_ram_write_address), 0);
        check({tag, "_data"},  32'(o_ram_data),          0);
        check({tag, "_busy"},  32'(o_busy),              0);
        check({tag, "_done"},  32'(o_done),              0);
        check({tag, "_ovf"},   32'(o_overflow),          0);
        check({tag, "_count"}, 32'(o_word_count),        0);
        check({tag, "_cpu"},   32'(o_cpu_enable),        0);
    endtask

    // Reference: words land at 0,1,2..; stop after HALT (0) or after the last address.
    task automatic run_load(input logic [15:0] words[$], input int maxgap, input string tag);
        int  n = 0;
        bit  halted = 1'b0;
        wr_t e;
        foreach (words[i]) begin
            e.a = NB_ADDR'(i);
            e.d = words[i];
            exp_q.push_back(e);
            n++;
            if (words[i] == 16'h0000) begin
                halted = 1'b1;
                break;
            end
            if (i == DEPTH - 1) break;
        end
        tick(1'b1, 1'b0, 8'h00);
        check({tag, "_busy_start"}, 32'(o_busy), 1);
        foreach (words[i]) begin
            send_byte(words[i][7:0],  int'($urandom_range(0, maxgap)));
            send_byte(words[i][15:8], int'($urandom_range(0, maxgap)));
        end
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        check({tag, "_done"},    32'(o_done),       32'(halted));
        check({tag, "_cpu"},     32'(o_cpu_enable), 32'(halted));
        check({tag, "_ovf"},     32'(o_overflow),   32'(!halted));
        check({tag, "_busy"},    32'(o_busy),       0);
        check({tag, "_count"},   32'(o_word_count), 32'(n));
        check({tag, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [15:0] words[$];
        logic [15:0] w;

        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h34, 0, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h12, 1, 0, 16'h1234, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hCD, 0, 1, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'hAB, 1, 1, 16'hABCD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 2, 16'h0000, 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 8'h00, 0, 2, 16'h0000, 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 8'h00, 1, 2, 16'h0000, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 2, 16'h0000, 0, 1, 0, 3));
        vecs.push_back(mk(0, 1, 8'h55, 0, 2, 16'h0000, 0, 1, 0, 3));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 0, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h00, 1, 0, 16'h0077, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 2));

        #2;
        check_all_zero("reset");
        @(posedge i_clock);
        @(posedge i_clock);
        #1 i_reset = 1'b0;

        foreach (vecs[i]) begin
            tick(vecs[i].start, vecs[i].valid, vecs[i].data);
            check($sformatf("vec%0d_we", i),    32'(o_ram_write_enable),  32'(vecs[i].we));
            check($sformatf("vec%0d_addr", i),  32'(o_ram_write_address), 32'(vecs[i].addr));
            if (vecs[i].we)
                check($sformatf("vec%0d_data", i), 32'(o_ram_data), 32'(vecs[i].wdata));
            check($sformatf("vec%0d_busy", i),  32'(o_busy),       32'(vecs[i].busy));
            check($sformatf("vec%0d_done", i),  32'(o_done),       32'(vecs[i].done));
            check($sformatf("vec%0d_cpu", i),   32'(o_cpu_enable), 32'(vecs[i].done));
            check($sformatf("vec%0d_ovf", i),   32'(o_overflow),   32'(vecs[i].ovf));
            check($sformatf("vec%0d_count", i), 32'(o_word_count), 32'(vecs[i].count));
        end

        mon_en = 1'b1;

        // Abort mid-stream: only the first completed word may have been written.
        exp_q.push_back('{a: '0, d: 16'h1234});
        tick(1'b1, 1'b0, 8'h00);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h56, 0);
        #3 i_reset = 1'b1;
        #1 check_all_zero("midreset");
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 1);
        check("midreset_busy_idle", 32'(o_busy), 0);
        check("midreset_pending", 32'(exp_q.size()), 0);

        words.delete();
        repeat (DEPTH) words.push_back(16'h1111);
        run_load(words, 1, "overflow");

        words.delete();
        repeat (DEPTH - 1) words.push_back(16'h1111);
        words.push_back(16'h0000);
        run_load(words, 1, "halt_last");

        for (int r = 0; r < 10; r++) begin
            int mode = int'($urandom_range(0, 2));
            int k;
            words.delete();
            if (mode == 0) begin
                k = DEPTH + int'($urandom_range(0, 3));
                for (int j = 0; j < k; j++) begin
                    w = 16'($urandom);
                    if (w == 16'h0000) w = 16'h0001;
                    words.push_back(w);
                end
            end else begin
                k = int'($urandom_range(0, DEPTH - 1));
                for (int j = 0; j < k; j++) begin
                    w = 16'($urandom);
                    if (w == 16'h0000) w = 16'h0001;
                    words.push_back(w);
                end
                words.push_back(16'h0000);
                for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                    words.push_back(16'($urandom));
            end
            run_load(words, 2, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
